// File: rtl/tpu_pkg.sv
// Shared types and sizing helpers for the weight staging path.
package tpu_pkg;

  typedef enum logic [0:0] {
    WTB_IDLE  = 1'b0,
    WTB_DRAIN = 1'b1
  } wtb_state_e;

  function automatic int tile_words(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int drain_beats(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Index width that stays at least one bit for single-entry dimensions.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_tile_bank.sv
// One tile of weight storage: single write port, one async read port per column.
module wt_tile_bank #(
  parameter int N_COLS    = 3,
  parameter int TILE_ROWS = 3,
  parameter int DATA_W    = 8,
  parameter int RW        = 2,
  parameter int CW        = 2
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [RW-1:0]            wr_row,
  input  logic [CW-1:0]            wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [N_COLS*RW-1:0]     rd_row,
  output logic [N_COLS*DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [TILE_ROWS][N_COLS];

  // Contents are only meaningful while the owning bank_full flag is set.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_row][wr_col] <= wr_data;
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < N_COLS; c++) begin
      rd_data[c*DATA_W +: DATA_W] = mem[rd_row[c*RW +: RW]][c];
    end
  end

endmodule

// File: rtl/weight_tile_buffer.sv
// Double-buffered weight tile staging: one bank fills from the DMA stream while
// the other drains into the systolic array with per-column diagonal skew.
module weight_tile_buffer
  import tpu_pkg::*;
#(
  parameter int N_COLS    = 3,
  parameter int TILE_ROWS = 3,
  parameter int DATA_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_start,
  output logic [N_COLS-1:0]        col_valid,
  output logic [N_COLS*DATA_W-1:0] col_data,
  output logic                     rd_done,
  output logic                     busy,
  output logic [1:0]               bank_full,
  output logic                     err_underrun
);

  localparam int DRAIN_BEATS = drain_beats(TILE_ROWS, N_COLS);
  localparam int RW = idx_w(TILE_ROWS);
  localparam int CW = idx_w(N_COLS);
  localparam int KW = idx_w(DRAIN_BEATS);
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(DRAIN_BEATS - 1);

  wtb_state_e state;
  logic [KW-1:0] k;
  logic fill_ptr, drain_ptr;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;

  // Write handshake: a word transfers on any rising edge where wr_valid && wr_ready;
  // wr_data must be stable while wr_valid is high and wr_ready is low.
  logic accept;
  assign wr_ready = !bank_full[fill_ptr];
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state == WTB_DRAIN);

  logic [N_COLS*RW-1:0]     rd_row;
  logic [N_COLS*DATA_W-1:0] rd_data0, rd_data1, sel_data, nxt_data;
  logic [N_COLS-1:0]        nxt_valid;
  logic [KW-1:0]            nxt_k;

  wt_tile_bank #(.N_COLS(N_COLS), .TILE_ROWS(TILE_ROWS), .DATA_W(DATA_W), .RW(RW), .CW(CW)) u_bank0 (
    .clk(clk), .wr_en(accept && !fill_ptr), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data0)
  );

  wt_tile_bank #(.N_COLS(N_COLS), .TILE_ROWS(TILE_ROWS), .DATA_W(DATA_W), .RW(RW), .CW(CW)) u_bank1 (
    .clk(clk), .wr_en(accept && fill_ptr), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data1)
  );

  assign sel_data = drain_ptr ? rd_data1 : rd_data0;

  // Outputs are registered, so address the beat that will be shown next cycle.
  always_comb begin
    nxt_k     = (state == WTB_DRAIN) ? k + 1'b1 : '0;
    rd_row    = '0;
    nxt_valid = '0;
    nxt_data  = '0;
    for (int c = 0; c < N_COLS; c++) begin
      if (int'(nxt_k) >= c && int'(nxt_k) - c < TILE_ROWS) begin
        nxt_valid[c]           = 1'b1;
        rd_row[c*RW +: RW]     = RW'(int'(nxt_k) - c);
      end
    end
    for (int c = 0; c < N_COLS; c++) begin
      if (nxt_valid[c]) nxt_data[c*DATA_W +: DATA_W] = sel_data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= WTB_IDLE;
      k            <= '0;
      fill_ptr     <= 1'b0;
      drain_ptr    <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      bank_full    <= '0;
      col_valid    <= '0;
      col_data     <= '0;
      rd_done      <= 1'b0;
      err_underrun <= 1'b0;
    end else if (flush) begin
      state        <= WTB_IDLE;
      k            <= '0;
      fill_ptr     <= 1'b0;
      drain_ptr    <= 1'b0;
      wr_row       <= '0;
      wr_col       <= '0;
      bank_full    <= '0;
      col_valid    <= '0;
      col_data     <= '0;
      rd_done      <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      if (accept) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          if (wr_row == ROW_LAST) begin
            wr_row              <= '0;
            bank_full[fill_ptr] <= 1'b1;
            fill_ptr            <= ~fill_ptr;
          end else begin
            wr_row <= wr_row + 1'b1;
          end
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end

      case (state)
        WTB_IDLE: begin
          if (rd_start) begin
            if (bank_full[drain_ptr]) begin
              state     <= WTB_DRAIN;
              k         <= '0;
              col_valid <= nxt_valid;
              col_data  <= nxt_data;
              rd_done   <= (K_LAST == '0);
            end else begin
              err_underrun <= 1'b1;
            end
          end
        end
        WTB_DRAIN: begin
          if (k == K_LAST) begin
            state                <= WTB_IDLE;
            col_valid            <= '0;
            col_data             <= '0;
            rd_done              <= 1'b0;
            bank_full[drain_ptr] <= 1'b0;
            drain_ptr            <= ~drain_ptr;
          end else begin
            k         <= nxt_k;
            col_valid <= nxt_valid;
            col_data  <= nxt_data;
            rd_done   <= (nxt_k == K_LAST);
          end
        end
        default: state <= WTB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_tile_buffer.sv
// Directed bench for weight_tile_buffer with a beat scoreboard built from a skew model.
module tb_weight_tile_buffer;

  localparam int N_COLS    = 3;
  localparam int TILE_ROWS = 3;
  localparam int DATA_W    = 8;
  localparam int BEATS     = TILE_ROWS + N_COLS - 1;
  localparam int WORDS     = TILE_ROWS * N_COLS;
  localparam int EW        = N_COLS + N_COLS * DATA_W + 1;
  localparam int TW        = WORDS * DATA_W;

  logic clk, rst, flush, wr_valid, rd_start;
  logic [DATA_W-1:0] wr_data;
  logic wr_ready, rd_done, busy, err_underrun;
  logic [N_COLS-1:0] col_valid;
  logic [N_COLS*DATA_W-1:0] col_data;
  logic [1:0] bank_full;

  logic [EW-1:0] exp_q[$];
  int pass_cnt;
  int total_cnt;

  weight_tile_buffer #(.N_COLS(N_COLS), .TILE_ROWS(TILE_ROWS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .rd_start(rd_start), .col_valid(col_valid), .col_data(col_data),
    .rd_done(rd_done), .busy(busy), .bank_full(bank_full), .err_underrun(err_underrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [TW-1:0] make_tile(input int base);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < WORDS; i++) t[i*DATA_W +: DATA_W] = DATA_W'(base + i);
    return t;
  endfunction

  // Beat k: column c shows row k-c of the row-major tile when that row exists.
  function automatic logic [EW-1:0] beat_exp(input logic [TW-1:0] tile, input int k);
    logic [N_COLS-1:0] v;
    logic [N_COLS*DATA_W-1:0] d;
    int r;
    v = '0;
    d = '0;
    for (int c = 0; c < N_COLS; c++) begin
      r = k - c;
      if (r >= 0 && r < TILE_ROWS) begin
        v[c] = 1'b1;
        d[c*DATA_W +: DATA_W] = tile[(r*N_COLS + c)*DATA_W +: DATA_W];
      end
    end
    return {v, d, (k == BEATS - 1)};
  endfunction

  // ---------------- drivers ----------------
  task automatic load_words(input logic [TW-1:0] tile, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 1)) step();
      wr_valid = 1'b1;
      wr_data  = tile[i*DATA_W +: DATA_W];
      t = 0;
      while (!wr_ready && t < 50) begin
        step();
        t++;
      end
      if (t == 50) check("wr_ready_timeout", {63'd0, wr_ready}, 64'd1);
      step();
      wr_valid = 1'b0;
    end
  endtask

  task automatic run_drain(input string tag, input logic [TW-1:0] tile);
    logic [EW-1:0] e;
    for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_exp(tile, k));
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_beat%0d", tag, k), 64'({col_valid, col_data, rd_done}), 64'(e));
      check($sformatf("%s_busy%0d", tag, k), {63'd0, busy}, 64'd1);
      step();
    end
    check({tag, "_idle_after"}, 64'({col_valid, col_data, rd_done, busy}), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TW-1:0] tile_a, tile_b, tile_c;
    logic [EW-1:0] e;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    wr_valid  = 1'b0;
    rd_start  = 1'b0;
    wr_data   = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    check("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
    check("rst_outputs", 64'({col_valid, col_data, rd_done, busy}), 64'd0);
    check("rst_bank_full", {62'd0, bank_full}, 64'd0);
    check("rst_err", {63'd0, err_underrun}, 64'd0);

    // Underrun: nothing loaded.
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check("underrun_err", {63'd0, err_underrun}, 64'd1);
    check("underrun_quiet", 64'({col_valid, busy}), 64'd0);
    repeat (3) step();
    check("underrun_sticky", {63'd0, err_underrun}, 64'd1);
    check("underrun_still_quiet", 64'({col_valid, busy}), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clears_err", {63'd0, err_underrun}, 64'd0);

    // Basic tile 1..9.
    tile_a = make_tile(1);
    load_words(tile_a, WORDS);
    check("t1_bank_full", {62'd0, bank_full}, 64'd1);
    run_drain("t1", tile_a);
    check("t1_bank_empty", {62'd0, bank_full}, 64'd0);

    // Two tiles back to back, 19th offer held.
    tile_a = make_tile(8'h10);
    tile_b = make_tile(8'h40);
    load_words(tile_a, WORDS);
    load_words(tile_b, WORDS);
    check("dbl_bank_full", {62'd0, bank_full}, 64'd3);
    check("dbl_wr_ready", {63'd0, wr_ready}, 64'd0);
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    repeat (3) step();
    check("held_wr_ready", {63'd0, wr_ready}, 64'd0);
    check("held_bank_full", {62'd0, bank_full}, 64'd3);
    wr_valid = 1'b0;
    run_drain("dbl_a", tile_a);
    check("dbl_wr_ready_after", {63'd0, wr_ready}, 64'd1);
    check("dbl_one_left", {62'd0, bank_full}, 64'd1);
    run_drain("dbl_b", tile_b);
    check("dbl_empty", {62'd0, bank_full}, 64'd0);

    // Fill the other bank while draining.
    tile_a = make_tile(8'h80);
    tile_b = make_tile(8'hC0);
    load_words(tile_a, WORDS);
    fork
      run_drain("conc_a", tile_a);
      load_words(tile_b, WORDS);
    join
    repeat (2) step();
    check("conc_b_full", {63'd0, |bank_full}, 64'd1);
    run_drain("conc_b", tile_b);

    // Reset during beat k2.
    tile_c = make_tile(8'h21);
    load_words(tile_c, WORDS);
    for (int k = 0; k < BEATS; k++) exp_q.push_back(beat_exp(tile_c, k));
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      check($sformatf("rstmid_beat%0d", k), 64'({col_valid, col_data, rd_done}), 64'(e));
      if (k < 2) step();
    end
    rst = 1'b1;
    exp_q.delete();
    step();
    check("rstmid_outputs", 64'({col_valid, col_data, rd_done, busy}), 64'd0);
    check("rstmid_bank_full", {62'd0, bank_full}, 64'd0);
    check("rstmid_wr_ready", {63'd0, wr_ready}, 64'd1);
    rst = 1'b0;
    step();
    tile_c = make_tile(8'h55);
    load_words(tile_c, WORDS);
    check("rstmid_reload_bank0", {62'd0, bank_full}, 64'd1);
    run_drain("rstmid_reload", tile_c);

    // Partial load discarded by flush.
    load_words(make_tile(8'hE0), 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_bank_full", {62'd0, bank_full}, 64'd0);
    check("flush_wr_ready", {63'd0, wr_ready}, 64'd1);
    tile_a = make_tile(1);
    load_words(tile_a, WORDS);
    check("flush_reload_bank0", {62'd0, bank_full}, 64'd1);
    run_drain("flush_reload", tile_a);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
